// File: rtl/frame_renderer.sv
`default_nettype none
// ============================================================================
// Module   : frame_renderer
// Purpose  : Streams a wall bitmap from synchronous RAM as VGA plots, then
//            overlays a clipped rectangular sprite.
// Revision : 1.0 - initial release
// ============================================================================
module frame_renderer #(
    parameter int                  GRID_W      = 120,
    parameter int                  GRID_H      = 100,
    parameter int                  X_OFF       = 20,
    parameter int                  Y_OFF       = 10,
    parameter int                  SPR_W       = 4,
    parameter int                  SPR_H       = 6,
    parameter int                  COORD_W     = 8,
    parameter int                  COLOUR_W    = 3,
    parameter logic [COLOUR_W-1:0] WALL_COLOUR = 3'b111,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000,
    parameter logic [COLOUR_W-1:0] SPR_COLOUR  = 3'b100,
    parameter int                  ADDR_W      = 14
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                spr_en,
    input  logic [COORD_W-1:0]  spr_x,
    input  logic [COORD_W-1:0]  spr_y,
    output logic [ADDR_W-1:0]   grid_rd_addr,
    input  logic                grid_rd_data,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int IW = (SPR_W  > 1) ? $clog2(SPR_W)  : 1;
    localparam int JW = (SPR_H  > 1) ? $clog2(SPR_H)  : 1;
    localparam int SW = COORD_W + 1;

    localparam logic [CW-1:0] COL_LAST = CW'(GRID_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(GRID_H - 1);
    localparam logic [IW-1:0] I_LAST   = IW'(SPR_W - 1);
    localparam logic [JW-1:0] J_LAST   = JW'(SPR_H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRID   = 2'd1,
        S_SPRITE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]       col_q, d1_col_q;
    logic [RW-1:0]       row_q, d1_row_q;
    logic                issued_all_q, d1_valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [IW-1:0]       i_q;
    logic [JW-1:0]       j_q;
    logic                spr_en_q;
    logic [COORD_W-1:0]  spr_x_q, spr_y_q;
    logic [COORD_W-1:0]  x_q, y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q, busy_q, done_q;

    logic                w_issue, w_issue_last, w_spr_last, w_clip;
    logic [SW-1:0]       w_spr_gx, w_spr_gy;
    logic [COORD_W-1:0]  w_grid_x, w_grid_y, w_spr_x, w_spr_y;

    assign w_issue      = (state_q == S_GRID) && !issued_all_q;
    assign w_issue_last = w_issue && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign w_spr_last   = (state_q == S_SPRITE) && (i_q == I_LAST) && (j_q == J_LAST);

    assign w_grid_x = COORD_W'(X_OFF) + COORD_W'(d1_col_q);
    assign w_grid_y = COORD_W'(Y_OFF) + COORD_W'(d1_row_q);

    // Grid-space sprite position is one bit wider so off-grid slots compare correctly.
    assign w_spr_gx = SW'(spr_x_q) + SW'(i_q);
    assign w_spr_gy = SW'(spr_y_q) + SW'(j_q);
    assign w_clip   = (w_spr_gx >= SW'(GRID_W)) || (w_spr_gy >= SW'(GRID_H));
    assign w_spr_x  = COORD_W'(X_OFF) + w_spr_gx[COORD_W-1:0];
    assign w_spr_y  = COORD_W'(Y_OFF) + w_spr_gy[COORD_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // GRID lingers one cycle after the last address so the read pipeline drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_GRID;
            S_GRID:   if (issued_all_q) state_d = spr_en_q ? S_SPRITE : S_FIN;
            S_SPRITE: if (w_spr_last) state_d = S_FIN;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q        <= '0;
            row_q        <= '0;
            d1_col_q     <= '0;
            d1_row_q     <= '0;
            issued_all_q <= 1'b0;
            d1_valid_q   <= 1'b0;
            addr_q       <= '0;
            i_q          <= '0;
            j_q          <= '0;
            spr_en_q     <= 1'b0;
            spr_x_q      <= '0;
            spr_y_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            plot_q     <= 1'b0;
            done_q     <= 1'b0;
            d1_valid_q <= w_issue;
            if (w_issue) begin
                d1_col_q <= col_q;
                d1_row_q <= row_q;
            end
            if (d1_valid_q) begin
                x_q      <= w_grid_x;
                y_q      <= w_grid_y;
                colour_q <= grid_rd_data ? WALL_COLOUR : BG_COLOUR;
                plot_q   <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        spr_en_q     <= spr_en;
                        spr_x_q      <= spr_x;
                        spr_y_q      <= spr_y;
                        busy_q       <= 1'b1;
                        addr_q       <= '0;
                        col_q        <= '0;
                        row_q        <= '0;
                        issued_all_q <= 1'b0;
                        i_q          <= '0;
                        j_q          <= '0;
                    end
                end
                S_GRID: begin
                    if (w_issue_last) begin
                        issued_all_q <= 1'b1;
                    end else if (w_issue) begin
                        addr_q <= addr_q + 1'b1;
                        if (row_q == ROW_LAST) begin
                            row_q <= '0;
                            col_q <= col_q + 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                S_SPRITE: begin
                    if (!w_clip) begin
                        x_q      <= w_spr_x;
                        y_q      <= w_spr_y;
                        colour_q <= SPR_COLOUR;
                        plot_q   <= 1'b1;
                    end
                    if (j_q == J_LAST) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                S_FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign grid_rd_addr = addr_q;
    assign x            = x_q;
    assign y            = y_q;
    assign colour       = colour_q;
    assign plot         = plot_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_renderer
// Purpose  : Scoreboard bench for frame_renderer (small grid and default grid).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_renderer;

    logic clk = 1'b0;
    logic resetn;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Small instance: 4x3 grid, 2x2 sprite
    logic       s_start, s_spr_en, s_rd, s_plot, s_busy, s_done;
    logic [7:0] s_spr_x, s_spr_y, s_x, s_y;
    logic [3:0] s_addr;
    logic [2:0] s_colour;
    logic       s_ram [0:11];

    frame_renderer #(
        .GRID_W(4), .GRID_H(3), .X_OFF(20), .Y_OFF(10),
        .SPR_W(2), .SPR_H(2), .ADDR_W(4)
    ) u_small (
        .clk(clk), .resetn(resetn), .start(s_start), .spr_en(s_spr_en),
        .spr_x(s_spr_x), .spr_y(s_spr_y), .grid_rd_addr(s_addr),
        .grid_rd_data(s_rd), .x(s_x), .y(s_y), .colour(s_colour),
        .plot(s_plot), .busy(s_busy), .done(s_done)
    );

    always @(posedge clk) s_rd <= (s_addr < 4'd12) ? s_ram[s_addr] : 1'b0;

    // Default instance
    logic        d_start, d_spr_en, d_rd, d_plot, d_busy, d_done;
    logic [7:0]  d_spr_x, d_spr_y, d_x, d_y;
    logic [13:0] d_addr;
    logic [2:0]  d_colour;
    logic        d_ram [0:11999];

    frame_renderer u_dflt (
        .clk(clk), .resetn(resetn), .start(d_start), .spr_en(d_spr_en),
        .spr_x(d_spr_x), .spr_y(d_spr_y), .grid_rd_addr(d_addr),
        .grid_rd_data(d_rd), .x(d_x), .y(d_y), .colour(d_colour),
        .plot(d_plot), .busy(d_busy), .done(d_done)
    );

    always @(posedge clk) d_rd <= (d_addr < 14'd12000) ? d_ram[d_addr] : 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input int px, input int py, input logic [2:0] c);
        return {13'd0, px[7:0], py[7:0], c};
    endfunction

    logic [31:0] s_q[$];
    logic [31:0] d_q[$];
    int s_nplot, s_first, s_last, s_ndone;
    int d_nplot, d_first, d_last, d_ndone, d_done_cyc;
    int s_dq[$];

    always @(negedge clk) begin
        if (s_plot) begin
            if (s_q.size() == 0) check("s_extra_plot", 32'd1, 32'd0);
            else check("s_pixel", pack(int'(s_x), int'(s_y), s_colour), s_q.pop_front());
            s_nplot++;
            if (s_first < 0) s_first = cyc;
            s_last = cyc;
        end
        if (s_done) begin
            s_ndone++;
            s_dq.push_back(cyc);
            check("s_busy_at_done", 32'(s_busy), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (d_plot) begin
            if (d_q.size() == 0) check("d_extra_plot", 32'd1, 32'd0);
            else check("d_pixel", pack(int'(d_x), int'(d_y), d_colour), d_q.pop_front());
            d_nplot++;
            if (d_first < 0) d_first = cyc;
            d_last = cyc;
        end
        if (d_done) begin
            d_ndone++;
            d_done_cyc = cyc;
        end
    end

    task automatic clr_small();
        s_nplot = 0; s_first = -1; s_last = -1; s_ndone = 0;
        s_dq.delete();
    endtask

    // Reference model: slot k of a frame is plotted after edge start+2+k.
    task automatic push_small(input logic en, input int sx, input int sy,
                              output int np, output int last_k, output int slots);
        int k;
        k = 0; np = 0; last_k = -1;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 3; r++) begin
                s_q.push_back(pack(20 + c, 10 + r, s_ram[c*3 + r] ? 3'b111 : 3'b000));
                np++; last_k = k; k++;
            end
        end
        if (en) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    if ((sx + i < 4) && (sy + j < 3)) begin
                        s_q.push_back(pack(20 + sx + i, 10 + sy + j, 3'b100));
                        np++; last_k = k;
                    end
                    k++;
                end
            end
        end
        slots = k;
    endtask

    task automatic frame_small(input string tag, input logic en, input logic [7:0] sx,
                               input logic [7:0] sy, input bit poke);
        int e, np, last_k, slots;
        clr_small();
        push_small(en, int'(sx), int'(sy), np, last_k, slots);
        s_spr_en = en; s_spr_x = sx; s_spr_y = sy; s_start = 1'b1;
        @(negedge clk);
        e = cyc;
        s_start = 1'b0;
        check({tag, "_busy"}, 32'(s_busy), 32'd1);
        check({tag, "_addr0"}, 32'(s_addr), 32'd0);
        if (poke) begin
            while (cyc < e + 5) @(negedge clk);
            s_start = 1'b1; s_spr_en = ~en; s_spr_x = 8'd0; s_spr_y = 8'd1;
            @(negedge clk);
            s_start = 1'b0;
        end
        for (int k = 0; k < 80 && s_ndone == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_ndone"},     32'(s_ndone), 32'd1);
        check({tag, "_done_cyc"},  32'(s_dq[0] - e), 32'(slots + 2));
        check({tag, "_nplot"},     32'(s_nplot), 32'(np));
        check({tag, "_first"},     32'(s_first - e), 32'd2);
        check({tag, "_last"},      32'(s_last - e), 32'(last_k + 2));
        check({tag, "_sb_empty"},  32'(s_q.size()), 32'd0);
        check({tag, "_idle_busy"}, 32'(s_busy), 32'd0);
    endtask

    initial begin
        int e, np, last_k, slots;
        resetn = 1'b1;
        s_start = 0; s_spr_en = 0; s_spr_x = 0; s_spr_y = 0;
        d_start = 0; d_spr_en = 0; d_spr_x = 0; d_spr_y = 0;
        for (int a = 0; a < 12; a++) s_ram[a] = (a == 5);
        for (int a = 0; a < 12000; a++) d_ram[a] = 1'b1;
        d_nplot = 0; d_first = -1; d_last = -1; d_ndone = 0; d_done_cyc = 0;
        clr_small();
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x",      32'(s_x), 32'd0);
        check("rst_y",      32'(s_y), 32'd0);
        check("rst_colour", 32'(s_colour), 32'd0);
        check("rst_plot",   32'(s_plot), 32'd0);
        check("rst_busy",   32'(s_busy), 32'd0);
        check("rst_done",   32'(s_done), 32'd0);
        check("rst_addr",   32'(s_addr), 32'd0);
        check("rst_d_addr", 32'(d_addr), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Grid only, then grid + sprite with mid-frame input noise, then clipping
        frame_small("t1", 1'b0, 8'd0, 8'd0, 1'b0);
        frame_small("t2", 1'b1, 8'd1, 8'd0, 1'b1);
        frame_small("t3", 1'b1, 8'd3, 8'd2, 1'b0);

        // Back-to-back frames with start held high
        clr_small();
        push_small(1'b1, 1, 0, np, last_k, slots);
        s_spr_en = 1'b1; s_spr_x = 8'd1; s_spr_y = 8'd0; s_start = 1'b1;
        @(negedge clk);
        e = cyc;
        while (cyc < e + 5) @(negedge clk);
        s_spr_x = 8'd0; s_spr_y = 8'd1;
        push_small(1'b1, 0, 1, np, last_k, slots);
        while (cyc < e + 25) @(negedge clk);
        s_spr_x = 8'd2;
        push_small(1'b1, 2, 1, np, last_k, slots);
        while (cyc < e + 40) @(negedge clk);
        s_start = 1'b0;
        while (cyc < e + 62) @(negedge clk);
        check("t4_ndone",    32'(s_ndone), 32'd3);
        check("t4_done0",    32'(s_dq[0] - e), 32'd18);
        check("t4_done1",    32'(s_dq[1] - e), 32'd37);
        check("t4_done2",    32'(s_dq[2] - e), 32'd56);
        check("t4_nplot",    32'(s_nplot), 32'd48);
        check("t4_sb_empty", 32'(s_q.size()), 32'd0);

        // Asynchronous reset mid-frame
        clr_small();
        push_small(1'b0, 0, 0, np, last_k, slots);
        s_spr_en = 1'b0; s_start = 1'b1;
        @(negedge clk);
        e = cyc;
        s_start = 1'b0;
        while (cyc < e + 7) @(negedge clk);
        check("t5_plot_pre", 32'(s_plot), 32'd1);
        resetn = 1'b0;
        #1;
        check("t5_plot", 32'(s_plot), 32'd0);
        check("t5_busy", 32'(s_busy), 32'd0);
        check("t5_done", 32'(s_done), 32'd0);
        check("t5_addr", 32'(s_addr), 32'd0);
        s_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_done", 32'(s_ndone), 32'd0);
        frame_small("t5_after", 1'b1, 8'd1, 8'd1, 1'b0);

        // Default parameters, full wall bitmap
        for (int c = 0; c < 120; c++)
            for (int r = 0; r < 100; r++)
                d_q.push_back(pack(20 + c, 10 + r, d_ram[c*100 + r] ? 3'b111 : 3'b000));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 6; j++)
                if ((30 + i < 120) && (94 + j < 100))
                    d_q.push_back(pack(50 + i, 104 + j, 3'b100));
        d_spr_en = 1'b1; d_spr_x = 8'd30; d_spr_y = 8'd94; d_start = 1'b1;
        @(negedge clk);
        e = cyc;
        d_start = 1'b0;
        for (int k = 0; k < 12100 && d_ndone == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t6_ndone",    32'(d_ndone), 32'd1);
        check("t6_done_cyc", 32'(d_done_cyc - e), 32'd12026);
        check("t6_nplot",    32'(d_nplot), 32'd12024);
        check("t6_first",    32'(d_first - e), 32'd2);
        check("t6_last",     32'(d_last - e), 32'd12025);
        check("t6_sb_empty", 32'(d_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
